// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// instruction fields, opcode/ALU code tables and DataPath bus bit indices.
package cpu_ctrl_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ALU_W   = 16;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned NUM_GPR = 16;

    localparam logic [ALU_W-1:0] ALU_INC_DEF  = 16'd16;
    localparam int unsigned      CSIGN_IX_DEF = 22;

    // Special (non-GPR) bit positions on the Rin/Rout buses
    localparam int unsigned BIT_Z   = 19;
    localparam int unsigned BIT_PC  = 20;
    localparam int unsigned BIT_MDR = 21;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1W  = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        IC_RTYPE,
        IC_ITYPE,
        IC_NOP,
        IC_HALT,
        IC_ILLEGAL
    } iclass_t;

    // C = {rc, rest}; only its sign-extended form is consumed, inside DataPath
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
        logic [14:0]      rest;
    } instr_t;

    localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd9;
    localparam logic [OP_W-1:0] OP_ANDI = 5'd10;
    localparam logic [OP_W-1:0] OP_ORI  = 5'd11;
    localparam logic [OP_W-1:0] OP_NOP  = 5'd14;
    localparam logic [OP_W-1:0] OP_HALT = 5'd15;

    localparam logic [ALU_W-1:0] ALU_ADD = 16'd0;
    localparam logic [ALU_W-1:0] ALU_AND = 16'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 16'd3;

    function automatic iclass_t classify(input logic [OP_W-1:0] op);
        if (op <= OP_ROL)                     return IC_RTYPE;
        else if (op >= OP_ADDI && op <= OP_ORI) return IC_ITYPE;
        else if (op == OP_NOP)                return IC_NOP;
        else if (op == OP_HALT)               return IC_HALT;
        else                                  return IC_ILLEGAL;
    endfunction

    // R-type ops drive their own opcode; immediates map onto the base ALU op
    function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI: return ALU_ADD;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_W'(op);
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] bit_mask(input int unsigned idx);
        return WORD_W'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register number to one-hot GPR select, forced to zero when not enabled.
module reg_select_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_W-1:0]   sel,
    input  logic               en,
    output logic [NUM_GPR-1:0] onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en) onehot_c[sel] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit driving DataPath strobes; outputs are
// Moore-decoded from the current T-step and the IR fields.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [ALU_W-1:0] ALU_INC  = ALU_INC_DEF,
    parameter int unsigned      CSIGN_IX = CSIGN_IX_DEF
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [WORD_W-1:0]   IR,
    input  logic                mem_ready,
    output logic [WORD_W-1:0]   Rin,
    output logic [WORD_W-1:0]   Rout,
    output logic                IRin,
    output logic                MARin,
    output logic                RYin,
    output logic                MDRread,
    output logic                RZout,
    output logic                RBin,
    output logic                PCjump,
    output logic [ALU_W-1:0]    ALUControl,
    output logic                halted,
    output logic                illegal,
    output logic [STATE_W-1:0]  state_o
);

    state_t             state;
    state_t             state_next;
    instr_t             instr;
    iclass_t            iclass;
    logic               alu_instr;
    logic [REG_W-1:0]   rout_sel;
    logic               rout_gpr_en;
    logic               rin_gpr_en;
    logic [NUM_GPR-1:0] rout_gpr;
    logic [NUM_GPR-1:0] rin_gpr;
    logic               unused_c;

    assign instr     = instr_t'(IR);
    assign iclass    = classify(instr.op);
    assign alu_instr = (iclass == IC_RTYPE) || (iclass == IC_ITYPE);
    assign unused_c  = ^instr.rest;

    // Source operand: Rb during T3, Rc during T4 (R-type only)
    assign rout_sel    = (state == S_T4) ? instr.rc : instr.rb;
    assign rout_gpr_en = ((state == S_T3) && alu_instr) ||
                         ((state == S_T4) && (iclass == IC_RTYPE));
    assign rin_gpr_en  = (state == S_T5);

    reg_select_decoder u_rout_dec (
        .sel      (rout_sel),
        .en       (rout_gpr_en),
        .onehot_c (rout_gpr)
    );

    reg_select_decoder u_rin_dec (
        .sel      (instr.ra),
        .en       (rin_gpr_en),
        .onehot_c (rin_gpr)
    );

    assign RZout   = 1'b0;
    assign RBin    = 1'b0;
    assign PCjump  = 1'b0;
    assign state_o = state;

    always_ff @(posedge clock) begin
        if (clear) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        Rin        = '0;
        Rout       = '0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        RYin       = 1'b0;
        MDRread    = 1'b0;
        ALUControl = '0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_next = S_T0;
            end
            S_T0: begin
                Rout       = bit_mask(BIT_PC);
                MARin      = 1'b1;
                Rin        = bit_mask(BIT_Z);
                ALUControl = ALU_INC;
                state_next = S_T1;
            end
            S_T1: begin
                Rout       = bit_mask(BIT_Z);
                Rin        = bit_mask(BIT_PC) | bit_mask(BIT_MDR);
                MDRread    = 1'b1;
                state_next = mem_ready ? S_T2 : S_T1W;
            end
            // Stall: keep the read alive but never reload PC a second time
            S_T1W: begin
                Rin     = bit_mask(BIT_MDR);
                MDRread = 1'b1;
                if (mem_ready) state_next = S_T2;
            end
            S_T2: begin
                Rout       = bit_mask(BIT_MDR);
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                case (iclass)
                    IC_RTYPE, IC_ITYPE: begin
                        Rout       = WORD_W'(rout_gpr);
                        RYin       = 1'b1;
                        state_next = S_T4;
                    end
                    IC_NOP:  state_next = S_T0;
                    IC_HALT: state_next = S_HALT;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_T0;
                    end
                endcase
            end
            S_T4: begin
                Rin        = bit_mask(BIT_Z);
                ALUControl = alu_code(instr.op);
                if (iclass == IC_ITYPE) Rout = bit_mask(CSIGN_IX);
                else                    Rout = WORD_W'(rout_gpr);
                state_next = S_T5;
            end
            S_T5: begin
                Rout       = bit_mask(BIT_Z);
                Rin        = WORD_W'(rin_gpr);
                state_next = S_T0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer: a per-cycle expectation
// list is built from instruction-level rules and compared every cycle.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] Rin, Rout;
    logic        IRin, MARin, RYin, MDRread, RZout, RBin, PCjump;
    logic [15:0] ALUControl;
    logic        halted, illegal;
    logic [3:0]  state_o;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .IR         (IR),
        .mem_ready  (mem_ready),
        .Rin        (Rin),
        .Rout       (Rout),
        .IRin       (IRin),
        .MARin      (MARin),
        .RYin       (RYin),
        .MDRread    (MDRread),
        .RZout      (RZout),
        .RBin       (RBin),
        .PCjump     (PCjump),
        .ALUControl (ALUControl),
        .halted     (halted),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    localparam int K_IDLE = 0, K_T0 = 1, K_T1 = 2, K_T1W = 3, K_T2 = 4,
                   K_T3 = 5, K_T4 = 6, K_T5 = 7, K_HALT = 8;

    typedef struct {
        int          kind;
        logic [31:0] ir;
        bit          mr;
        bit          st;
        bit          cl;
        bit          chk;
        bit          lit;
        logic [31:0] lrout;
        logic [31:0] lrin;
        logic [15:0] lalu;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void add(input int k, input logic [31:0] ir, input bit mr,
                                input bit st, input bit cl, input bit chk);
        rec_t r;
        r.kind = k; r.ir = ir; r.mr = mr; r.st = st; r.cl = cl; r.chk = chk;
        r.lit = 1'b0; r.lrout = '0; r.lrin = '0; r.lalu = '0;
        q.push_back(r);
    endfunction

    function automatic void set_lit(input int idx, input logic [31:0] ro,
                                    input logic [31:0] ri, input logic [15:0] al);
        rec_t r;
        r = q[idx];
        r.lit = 1'b1; r.lrout = ro; r.lrin = ri; r.lalu = al;
        q[idx] = r;
    endfunction

    function automatic logic [31:0] make_ir(input int op);
        logic [31:0] v;
        v = $urandom();
        v[31:27] = 5'(op);
        return v;
    endfunction

    function automatic int pick_op();
        int r, x;
        r = int'($urandom_range(0, 19));
        if (r <= 8)  return int'($urandom_range(0, 8));
        if (r <= 12) return int'($urandom_range(9, 11));
        if (r <= 14) return 14;
        if (r == 15) return 15;
        x = int'($urandom_range(0, 17));
        return (x < 2) ? 12 + x : 16 + (x - 2);
    endfunction

    // What every output must be in one cycle, from the instruction-level rules
    function automatic void model(input int k, input logic [31:0] ir,
                                  output logic [31:0] rin, output logic [31:0] rout,
                                  output logic [15:0] alu, output logic irin,
                                  output logic marin, output logic ryin,
                                  output logic mdr, output logic hal, output logic ill);
        int op, ra, rb, rc;
        bit rt, it;
        op = int'(ir[31:27]); ra = int'(ir[26:23]);
        rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        rt = (op <= 8);
        it = (op >= 9 && op <= 11);
        rin = '0; rout = '0; alu = '0; irin = 0; marin = 0; ryin = 0;
        mdr = 0; hal = 0; ill = 0;
        case (k)
            K_T0:  begin rout = 32'h0010_0000; marin = 1; rin = 32'h0008_0000; alu = 16'd16; end
            K_T1:  begin rout = 32'h0008_0000; rin = 32'h0030_0000; mdr = 1; end
            K_T1W: begin rin = 32'h0020_0000; mdr = 1; end
            K_T2:  begin rout = 32'h0020_0000; irin = 1; end
            K_T3: begin
                if (rt || it) begin rout = 32'(1) << rb; ryin = 1; end
                else if (op != 14 && op != 15) ill = 1;
            end
            K_T4: begin
                rin = 32'h0008_0000;
                if (rt) begin rout = 32'(1) << rc; alu = 16'(op); end
                else begin rout = 32'h0040_0000; alu = (op == 9) ? 16'd0 : (op == 10) ? 16'd2 : 16'd3; end
            end
            K_T5:   begin rout = 32'h0008_0000; rin = 32'(1) << ra; end
            K_HALT: hal = 1;
            default: ;
        endcase
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", nm, cyc, act, exp);
        end
    endtask

    task automatic begin_instr(input bit idle);
        if (idle) begin
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                add(K_IDLE, $urandom(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
            add(K_IDLE, $urandom(), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        end
    endtask

    // One instruction: w wait cycles, optional clear at step clr_at, halt_n HALT cycles
    task automatic gen_instr(input logic [31:0] ir, input int w, input int clr_at,
                             input int halt_n, output bit idle);
        int ks[$];
        bit ms[$];
        int op;
        bit cl;
        logic [31:0] irv;
        op = int'(ir[31:27]);
        ks.push_back(K_T0); ms.push_back(1'($urandom_range(0, 1)));
        ks.push_back(K_T1); ms.push_back(w == 0);
        for (int i = 0; i < w; i++) begin ks.push_back(K_T1W); ms.push_back(i == w - 1); end
        ks.push_back(K_T2); ms.push_back(1'($urandom_range(0, 1)));
        ks.push_back(K_T3); ms.push_back(1'($urandom_range(0, 1)));
        if (op <= 11) begin
            ks.push_back(K_T4); ms.push_back(1'($urandom_range(0, 1)));
            ks.push_back(K_T5); ms.push_back(1'($urandom_range(0, 1)));
        end else if (op == 15) begin
            for (int i = 0; i < halt_n; i++) begin
                ks.push_back(K_HALT); ms.push_back(1'($urandom_range(0, 1)));
            end
        end
        idle = 1'b0;
        for (int i = 0; i < ks.size(); i++) begin
            cl  = (i == clr_at) || (ks[i] == K_HALT && i == ks.size() - 1);
            irv = (ks[i] >= K_T3 && ks[i] <= K_T5) ? ir : $urandom();
            add(ks[i], irv, ms[i], 1'($urandom_range(0, 1)), cl, 1'b1);
            if (cl) begin idle = 1'b1; break; end
        end
    endtask

    initial begin
        bit idle;
        int n;
        rec_t r;
        logic [31:0] e_rin, e_rout;
        logic [15:0] e_alu;
        logic e_irin, e_marin, e_ryin, e_mdr, e_hal, e_ill;

        add(K_IDLE, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(K_IDLE, $urandom(), 1'b1, 1'b0, 1'b0, 1'b1);
        add(K_IDLE, $urandom(), 1'b1, 1'b1, 1'b1, 1'b1);
        add(K_IDLE, $urandom(), 1'b0, 1'b1, 1'b0, 1'b1);

        gen_instr(32'h4382_0000, 0, -1, 0, idle);
        n = q.size();
        set_lit(n - 3, 32'h0000_0001, 32'h0000_0000, 16'd0);
        set_lit(n - 2, 32'h0000_0010, 32'h0008_0000, 16'd8);
        set_lit(n - 1, 32'h0008_0000, 32'h0000_0080, 16'd0);

        gen_instr(32'h490F_FFFB, 0, -1, 0, idle);
        n = q.size();
        set_lit(n - 3, 32'h0000_0002, 32'h0000_0000, 16'd0);
        set_lit(n - 2, 32'h0040_0000, 32'h0008_0000, 16'd0);
        set_lit(n - 1, 32'h0008_0000, 32'h0000_0004, 16'd0);

        gen_instr(make_ir(0), 3, -1, 0, idle);
        gen_instr(make_ir(13), 0, -1, 0, idle);
        gen_instr(make_ir(14), 1, -1, 0, idle);
        gen_instr(make_ir(0), 0, 4, 0, idle);
        begin_instr(idle);
        gen_instr(make_ir(1), 4, 3, 0, idle);
        begin_instr(idle);
        gen_instr(make_ir(15), 0, -1, 10, idle);

        for (int t = 0; t < 150; t++) begin
            int w;
            int ca;
            begin_instr(idle);
            w  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            ca = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
            gen_instr(make_ir(pick_op()), w, ca, int'($urandom_range(1, 6)), idle);
        end

        @(posedge clock);
        #1;
        for (int i = 0; i < q.size(); i++) begin
            r = q[i];
            IR = r.ir; mem_ready = r.mr; start = r.st; clear = r.cl;
            @(negedge clock);
            if (r.chk) begin
                model(r.kind, r.ir, e_rin, e_rout, e_alu, e_irin, e_marin, e_ryin,
                      e_mdr, e_hal, e_ill);
                chk("state", i, 32'(state_o), 32'(r.kind));
                chk("Rin", i, Rin, e_rin);
                chk("Rout", i, Rout, e_rout);
                chk("ALUControl", i, 32'(ALUControl), 32'(e_alu));
                chk("IRin", i, 32'(IRin), 32'(e_irin));
                chk("MARin", i, 32'(MARin), 32'(e_marin));
                chk("RYin", i, 32'(RYin), 32'(e_ryin));
                chk("MDRread", i, 32'(MDRread), 32'(e_mdr));
                chk("halted", i, 32'(halted), 32'(e_hal));
                chk("illegal", i, 32'(illegal), 32'(e_ill));
                chk("reserved", i, 32'({RZout, RBin, PCjump}), 32'(0));
                chk("rout_onehot", i, 32'($countones(Rout) <= 1), 32'(1));
                chk("rin_gpr_onehot", i, 32'($countones(Rin[15:0]) <= 1), 32'(1));
            end
            if (r.lit) begin
                chk("lit_Rout", i, Rout, r.lrout);
                chk("lit_Rin", i, Rin, r.lrin);
                chk("lit_ALU", i, 32'(ALUControl), 32'(r.lalu));
            end
            @(posedge clock);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
